// File: rtl/multicycle_controller.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK over one
// shared memory port with a ready handshake, plus a sticky illegal-instruction trap.
module multicycle_controller #(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          TRAP_EN     = 1'b1,
  parameter int unsigned ALUCTRL_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instruction,
  input  logic                 ALUZero,
  input  logic                 memReady,
  output logic                 PCWr,
  output logic                 IRWr,
  output logic                 memRd,
  output logic                 memWr,
  output logic [ALUCTRL_W-1:0] ALUCtrl,
  output logic                 ALUImm,
  output logic                 ALUToPC,
  output logic                 branch,
  output logic                 memToReg,
  output logic                 regWr,
  output logic                 rs2ShiftSel,
  output logic                 uext,
  output logic [1:0]           loadSel,
  output logic [1:0]           maskSel,
  output logic [1:0]           regDataSel,
  output logic                 illegal,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_FENCE  = 5'b00011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic [4:0] opc;
  logic [2:0] funct3;
  logic       funct7_5, quad_ok;
  logic       is_r, is_imm, is_load, is_store, is_branch, is_lui, is_auipc;
  logic       is_jal, is_jalr, is_fence, is_sys, is_legal, mem_rdy, uses_imm;
  logic [3:0] alu_op, br_alu_op;
  logic       br_take;
  logic       unused_instr;

  logic                 pc_wr, ir_wr, mem_rd, mem_wr, alu_imm, alu_to_pc;
  logic                 br_out, mem_to_reg, reg_wr;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  logic [1:0]           reg_data_sel;

  assign opc          = instruction[6:2];
  assign funct3       = instruction[14:12];
  assign funct7_5     = instruction[30];
  assign quad_ok      = (instruction[1:0] == 2'b11);
  assign unused_instr = ^{instruction[31], instruction[29:15], instruction[11:7]};

  assign is_r      = quad_ok && (opc == OP_R);
  assign is_imm    = quad_ok && (opc == OP_IMM);
  assign is_load   = quad_ok && (opc == OP_LOAD);
  assign is_store  = quad_ok && (opc == OP_STORE);
  assign is_branch = quad_ok && (opc == OP_BRANCH);
  assign is_lui    = quad_ok && (opc == OP_LUI);
  assign is_auipc  = quad_ok && (opc == OP_AUIPC);
  assign is_jal    = quad_ok && (opc == OP_JAL);
  assign is_jalr   = quad_ok && (opc == OP_JALR);
  assign is_fence  = quad_ok && (opc == OP_FENCE);
  assign is_sys    = quad_ok && (opc == OP_SYSTEM);
  assign is_legal  = is_r | is_imm | is_load | is_store | is_branch | is_lui |
                     is_auipc | is_jal | is_jalr | is_fence | is_sys;
  assign mem_rdy   = memReady | ~MEM_WAIT_EN;
  assign uses_imm  = is_imm | is_load | is_store | is_jalr;

  // Branch compare operation and taken condition from funct3
  always_comb begin
    br_alu_op = ALU_ADD;
    br_take   = 1'b0;
    case (funct3)
      3'b000: begin br_alu_op = ALU_SUB;  br_take = ALUZero;  end
      3'b001: begin br_alu_op = ALU_SUB;  br_take = ~ALUZero; end
      3'b100: begin br_alu_op = ALU_SLT;  br_take = ~ALUZero; end
      3'b101: begin br_alu_op = ALU_SLT;  br_take = ALUZero;  end
      3'b110: begin br_alu_op = ALU_SLTU; br_take = ~ALUZero; end
      3'b111: begin br_alu_op = ALU_SLTU; br_take = ALUZero;  end
      default: ;
    endcase
  end

  // ALU operation for the current instruction class
  always_comb begin
    alu_op = ALU_ADD;
    if (is_r || is_imm) begin
      case (funct3)
        3'b000: alu_op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001: alu_op = ALU_SLL;
        3'b010: alu_op = ALU_SLT;
        3'b011: alu_op = ALU_SLTU;
        3'b100: alu_op = ALU_XOR;
        3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110: alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end else if (is_branch) begin
      alu_op = br_alu_op;
    end
  end

  // Next-state and control outputs
  always_comb begin
    state_d      = state_q;
    pc_wr        = 1'b0;
    ir_wr        = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    alu_ctrl     = '0;
    alu_imm      = 1'b0;
    alu_to_pc    = 1'b0;
    br_out       = 1'b0;
    mem_to_reg   = 1'b0;
    reg_wr       = 1'b0;
    reg_data_sel = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          ir_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (!is_legal && TRAP_EN) ? S_TRAP : S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_ctrl = ALUCTRL_W'(alu_op);
        alu_imm  = uses_imm;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          br_out  = br_take;
          pc_wr   = 1'b1;
          state_d = S_FETCH;
        end else if (is_r || is_imm || is_lui || is_auipc || is_jal || is_jalr) begin
          state_d = S_WRITEBACK;
        end else begin
          pc_wr   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        alu_ctrl = ALUCTRL_W'(alu_op);
        alu_imm  = uses_imm;
        if (is_load) begin
          mem_rd     = 1'b1;
          mem_to_reg = 1'b1;
          if (mem_rdy) state_d = S_WRITEBACK;
        end else begin
          mem_wr = 1'b1;
          if (mem_rdy) begin
            pc_wr   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        alu_ctrl   = ALUCTRL_W'(alu_op);
        alu_imm    = uses_imm;
        reg_wr     = 1'b1;
        pc_wr      = 1'b1;
        mem_to_reg = is_load;
        br_out     = is_jal | is_jalr;
        alu_to_pc  = is_jalr;
        if (is_lui)                 reg_data_sel = 2'b01;
        else if (is_auipc)          reg_data_sel = 2'b10;
        else if (is_jal || is_jalr) reg_data_sel = 2'b11;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  // State and sticky trap flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Every output is forced low while reset is high
  assign PCWr        = pc_wr & ~reset;
  assign IRWr        = ir_wr & ~reset;
  assign memRd       = mem_rd & ~reset;
  assign memWr       = mem_wr & ~reset;
  assign ALUCtrl     = reset ? '0 : alu_ctrl;
  assign ALUImm      = alu_imm & ~reset;
  assign ALUToPC     = alu_to_pc & ~reset;
  assign branch      = br_out & ~reset;
  assign memToReg    = mem_to_reg & ~reset;
  assign regWr       = reg_wr & ~reset;
  assign rs2ShiftSel = funct3[0] & ~reset;
  assign uext        = funct3[2] & ~reset;
  assign loadSel     = reset ? 2'b00 : funct3[1:0];
  assign maskSel     = reset ? 2'b00 : funct3[1:0];
  assign regDataSel  = reset ? 2'b00 : reg_data_sel;
  assign illegal     = illegal_q & ~reset;
  assign state       = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: default instance plus a
// TRAP_EN=0 / MEM_WAIT_EN=0 instance sharing the same inputs.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        ALUZero, memReady;

  logic       PCWr, IRWr, memRd, memWr, ALUImm, ALUToPC, branch, memToReg, regWr;
  logic       rs2ShiftSel, uext, illegal;
  logic [3:0] ALUCtrl;
  logic [1:0] loadSel, maskSel, regDataSel;
  logic [2:0] state;

  logic       nt_PCWr, nt_IRWr, nt_memRd, nt_memWr, nt_ALUImm, nt_ALUToPC, nt_branch;
  logic       nt_memToReg, nt_regWr, nt_rs2ShiftSel, nt_uext, nt_illegal;
  logic [3:0] nt_ALUCtrl;
  logic [1:0] nt_loadSel, nt_maskSel, nt_regDataSel;
  logic [2:0] nt_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .instruction(instruction), .ALUZero(ALUZero),
    .memReady(memReady), .PCWr(PCWr), .IRWr(IRWr), .memRd(memRd), .memWr(memWr),
    .ALUCtrl(ALUCtrl), .ALUImm(ALUImm), .ALUToPC(ALUToPC), .branch(branch),
    .memToReg(memToReg), .regWr(regWr), .rs2ShiftSel(rs2ShiftSel), .uext(uext),
    .loadSel(loadSel), .maskSel(maskSel), .regDataSel(regDataSel),
    .illegal(illegal), .state(state)
  );

  multicycle_controller #(.MEM_WAIT_EN(1'b0), .TRAP_EN(1'b0), .ALUCTRL_W(4)) dut_nt (
    .clk(clk), .reset(reset), .instruction(instruction), .ALUZero(ALUZero),
    .memReady(memReady), .PCWr(nt_PCWr), .IRWr(nt_IRWr), .memRd(nt_memRd),
    .memWr(nt_memWr), .ALUCtrl(nt_ALUCtrl), .ALUImm(nt_ALUImm),
    .ALUToPC(nt_ALUToPC), .branch(nt_branch), .memToReg(nt_memToReg),
    .regWr(nt_regWr), .rs2ShiftSel(nt_rs2ShiftSel), .uext(nt_uext),
    .loadSel(nt_loadSel), .maskSel(nt_maskSel), .regDataSel(nt_regDataSel),
    .illegal(nt_illegal), .state(nt_state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive handshake inputs just after the edge, then sample at the falling edge
  task automatic at_cycle(input logic mr, input logic z);
    memReady = mr;
    ALUZero  = z;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four-cycle register-writing instruction: FETCH, DECODE, EXECUTE, WRITEBACK
  task automatic exec_wb(input string tag, input logic [31:0] ins, input logic [3:0] e_alu,
                         input logic e_imm, input logic [1:0] e_rds, input logic e_br,
                         input logic e_a2pc);
    instruction = ins;
    at_cycle(1'b1, 1'b0);
    check({tag, " F state"}, 32'(state), 0);
    check({tag, " F IRWr"}, 32'(IRWr), 1);
    tick();
    at_cycle(1'b0, 1'b0);
    check({tag, " D state"}, 32'(state), 1);
    tick();
    at_cycle(1'b0, 1'b0);
    check({tag, " E state"}, 32'(state), 2);
    check({tag, " E ALUCtrl"}, 32'(ALUCtrl), 32'(e_alu));
    check({tag, " E PCWr"}, 32'(PCWr), 0);
    tick();
    at_cycle(1'b0, 1'b0);
    check({tag, " WB state"}, 32'(state), 4);
    check({tag, " WB ALUCtrl"}, 32'(ALUCtrl), 32'(e_alu));
    check({tag, " WB ALUImm"}, 32'(ALUImm), 32'(e_imm));
    check({tag, " WB regDataSel"}, 32'(regDataSel), 32'(e_rds));
    check({tag, " WB branch"}, 32'(branch), 32'(e_br));
    check({tag, " WB ALUToPC"}, 32'(ALUToPC), 32'(e_a2pc));
    check({tag, " WB regWr"}, 32'(regWr), 1);
    check({tag, " WB PCWr"}, 32'(PCWr), 1);
    tick();
  endtask

  // Three-cycle conditional branch: FETCH, DECODE, EXECUTE
  task automatic exec_branch(input string tag, input logic [31:0] ins, input logic z,
                             input logic [3:0] e_alu, input logic e_br);
    instruction = ins;
    at_cycle(1'b1, 1'b0);
    check({tag, " F state"}, 32'(state), 0);
    tick();
    at_cycle(1'b0, z);
    check({tag, " D state"}, 32'(state), 1);
    tick();
    at_cycle(1'b0, z);
    check({tag, " E state"}, 32'(state), 2);
    check({tag, " E ALUCtrl"}, 32'(ALUCtrl), 32'(e_alu));
    check({tag, " E branch"}, 32'(branch), 32'(e_br));
    check({tag, " E PCWr"}, 32'(PCWr), 1);
    check({tag, " E regWr"}, 32'(regWr), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    instruction = 32'h0;
    memReady    = 1'b1;
    ALUZero     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", 32'(state), 0);
    check("reset memRd", 32'(memRd), 0);
    check("reset IRWr", 32'(IRWr), 0);
    check("reset illegal", 32'(illegal), 0);
    tick();
    reset = 1'b0;

    exec_wb("ADD",  32'h002081B3, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);
    exec_wb("SUB",  32'h402081B3, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0);
    exec_wb("SRAI", 32'h4030D093, 4'b0111, 1'b1, 2'b00, 1'b0, 1'b0);
    exec_wb("AND",  32'h0020F1B3, 4'b0010, 1'b0, 2'b00, 1'b0, 1'b0);
    exec_wb("ADDI", 32'hC0008093, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    exec_wb("LUI",  32'h123450B7, 4'b0000, 1'b0, 2'b01, 1'b0, 1'b0);
    exec_wb("JAL",  32'h000000EF, 4'b0000, 1'b0, 2'b11, 1'b1, 1'b0);
    exec_wb("JALR", 32'h000100E7, 4'b0000, 1'b1, 2'b11, 1'b1, 1'b1);

    // LW with two MEM wait cycles
    instruction = 32'h0040A283;
    at_cycle(1'b1, 1'b0);
    check("LW F IRWr", 32'(IRWr), 1);
    tick();
    at_cycle(1'b0, 1'b0);
    check("LW D state", 32'(state), 1);
    tick();
    at_cycle(1'b0, 1'b0);
    check("LW E state", 32'(state), 2);
    check("LW E ALUImm", 32'(ALUImm), 1);
    tick();
    at_cycle(1'b0, 1'b0);
    check("LW M1 state", 32'(state), 3);
    check("LW M1 memRd", 32'(memRd), 1);
    check("LW M1 memToReg", 32'(memToReg), 1);
    check("LW M1 PCWr", 32'(PCWr), 0);
    tick();
    at_cycle(1'b0, 1'b0);
    check("LW M2 state", 32'(state), 3);
    tick();
    at_cycle(1'b1, 1'b0);
    check("LW M3 state", 32'(state), 3);
    check("LW M3 regWr", 32'(regWr), 0);
    tick();
    at_cycle(1'b0, 1'b0);
    check("LW WB state", 32'(state), 4);
    check("LW WB memToReg", 32'(memToReg), 1);
    check("LW WB regWr", 32'(regWr), 1);
    check("LW WB loadSel", 32'(loadSel), 2);
    check("LW WB uext", 32'(uext), 0);
    check("LW WB PCWr", 32'(PCWr), 1);
    tick();

    // SW, memory ready on the first MEM cycle
    instruction = 32'h0050A423;
    at_cycle(1'b1, 1'b0);
    check("SW F state", 32'(state), 0);
    tick();
    at_cycle(1'b0, 1'b0);
    tick();
    at_cycle(1'b0, 1'b0);
    check("SW E state", 32'(state), 2);
    check("SW E ALUImm", 32'(ALUImm), 1);
    check("SW E regWr", 32'(regWr), 0);
    tick();
    at_cycle(1'b1, 1'b0);
    check("SW M state", 32'(state), 3);
    check("SW M memWr", 32'(memWr), 1);
    check("SW M PCWr", 32'(PCWr), 1);
    check("SW M regWr", 32'(regWr), 0);
    check("SW M memRd", 32'(memRd), 0);
    tick();
    at_cycle(1'b0, 1'b0);
    check("SW next state", 32'(state), 0);
    check("SW next memWr", 32'(memWr), 0);
    check("fetch wait IRWr", 32'(IRWr), 0);
    check("fetch wait memRd", 32'(memRd), 1);
    tick();

    exec_branch("BEQ z1",  32'h00208463, 1'b1, 4'b0001, 1'b1);
    exec_branch("BEQ z0",  32'h00208463, 1'b0, 4'b0001, 1'b0);
    exec_branch("BNE z0",  32'h00209463, 1'b0, 4'b0001, 1'b1);
    exec_branch("BGE z1",  32'h0020D463, 1'b1, 4'b1000, 1'b1);
    exec_branch("BLTU z1", 32'h0020E463, 1'b1, 4'b1001, 1'b0);
    at_cycle(1'b0, 1'b0);
    check("after branch state", 32'(state), 0);

    // Illegal opcode: trap on the default instance, NOP on the other
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    instruction = 32'h00000000;
    at_cycle(1'b0, 1'b0);
    check("TRAP c0 state", 32'(state), 0);
    check("TRAP c0 IRWr", 32'(IRWr), 0);
    check("NT c0 IRWr", 32'(nt_IRWr), 1);
    tick();
    at_cycle(1'b1, 1'b0);
    check("TRAP c1 IRWr", 32'(IRWr), 1);
    check("NT c1 state", 32'(nt_state), 1);
    tick();
    at_cycle(1'b0, 1'b0);
    check("TRAP c2 state", 32'(state), 1);
    check("TRAP c2 PCWr", 32'(PCWr), 0);
    check("NT c2 state", 32'(nt_state), 2);
    check("NT c2 PCWr", 32'(nt_PCWr), 1);
    check("NT c2 regWr", 32'(nt_regWr), 0);
    check("NT c2 illegal", 32'(nt_illegal), 0);
    tick();
    at_cycle(1'b0, 1'b0);
    check("TRAP c3 state", 32'(state), 5);
    check("TRAP c3 illegal", 32'(illegal), 1);
    check("TRAP c3 PCWr", 32'(PCWr), 0);
    check("NT c3 state", 32'(nt_state), 0);
    tick();
    at_cycle(1'b1, 1'b0);
    check("TRAP c4 state", 32'(state), 5);
    check("TRAP c4 illegal", 32'(illegal), 1);
    check("TRAP c4 memRd", 32'(memRd), 0);
    check("TRAP c4 IRWr", 32'(IRWr), 0);
    tick();
    reset = 1'b1;
    at_cycle(1'b1, 1'b0);
    check("TRAP in reset illegal", 32'(illegal), 0);
    tick();
    reset = 1'b0;
    at_cycle(1'b0, 1'b0);
    check("TRAP cleared illegal", 32'(illegal), 0);
    check("TRAP cleared state", 32'(state), 0);
    tick();

    // Reset during a stalled store
    instruction = 32'h0050A423;
    at_cycle(1'b1, 1'b0);
    tick();
    at_cycle(1'b0, 1'b0);
    tick();
    at_cycle(1'b0, 1'b0);
    tick();
    at_cycle(1'b0, 1'b0);
    check("RST SW M state", 32'(state), 3);
    check("RST SW M memWr", 32'(memWr), 1);
    check("RST SW M PCWr", 32'(PCWr), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    at_cycle(1'b0, 1'b0);
    check("RST after state", 32'(state), 0);
    check("RST after memWr", 32'(memWr), 0);
    check("RST after PCWr", 32'(PCWr), 0);
    check("RST after memRd", 32'(memRd), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle successor to the single-cycle RV32I decoder. Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK using one shared memory port with a ready handshake.
- Sits between the instruction register, datapath and memory bus. Drives the same datapath control set as the single-cycle core, plus PC/IR write enables, memory strobes and an illegal-instruction trap.

Parameters:
- MEM_WAIT_EN, 1, 1 = FETCH/MEM hold until memReady; 0 = memReady is ignored and memory is treated as always ready.
- TRAP_EN, 1, 1 = an unknown opcode enters TRAP; 0 = an unknown opcode retires as a NOP (PCWr only).
- ALUCTRL_W, 4, width of ALUCtrl. Must be ≥4; upper bits are zero.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- instruction  in  32  IR contents; stable from DECODE until the instruction retires
- ALUZero  in  1  ALU result == 0
- memReady  in  1  memory completed the current access this cycle
- PCWr  out  1  PC update strobe, exactly one cycle per retired instruction
- IRWr  out  1  latch fetched word into IR
- memRd  out  1  memory read request (fetch or load)
- memWr  out  1  memory write request (store)
- ALUCtrl  out  ALUCTRL_W  ALU operation
- ALUImm, ALUToPC, branch, memToReg, regWr, rs2ShiftSel, uext  out  1  datapath controls, same meaning as the single-cycle core
- loadSel, maskSel, regDataSel  out  2  datapath selects, same meaning as the single-cycle core
- illegal  out  1  sticky trap flag
- state  out  3  current state, for debug

Behaviour:
- Reset, synchronous: state=FETCH(0) and illegal=0. Every output is 0 during any cycle with reset high, and reset overrides all transitions including mid-access.
- State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5. Codes 6 and 7 go to FETCH.
- Defaults per cycle: all strobes 0. loadSel=maskSel=funct3[1:0], rs2ShiftSel=funct3[0], uext=funct3[2].
- FETCH: memRd=1. When memReady (or MEM_WAIT_EN=0), IRWr=1 and go to DECODE; otherwise stay.
- DECODE: no strobes. If opcode[1:0]≠11 or opcode[6:2] is not in {01100, 00100, 00000, 01000, 11000, 01101, 00101, 11011, 11001, 00011, 11100}:
  - TRAP_EN=1: go to TRAP.
  - TRAP_EN=0: go to EXECUTE as a NOP.
  - Otherwise go to EXECUTE.
- ALUCtrl codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
  - R-type ADD/SUB and SRL/SRA are selected by funct7[5]. OP-IMM uses funct7[5] only for funct3=101.
  - ALUCtrl and ALUImm are held constant through EXECUTE, MEM and WRITEBACK of the same instruction.
- EXECUTE, per class:
  - R-type / OP-IMM / LUI / AUIPC / JAL / JALR: go to WRITEBACK.
  - Load / store: ALUImm=1, go to MEM.
  - Branch: ALUCtrl from funct3 (BEQ/BNE→0001, BLT/BGE→1000, BLTU/BGEU→1001).
    - branch=ALUZero for BEQ/BGE/BGEU; branch=~ALUZero for BNE/BLT/BLTU; branch=0 for funct3 010/011.
    - PCWr=1, go to FETCH.
  - FENCE / SYSTEM / NOP: PCWr=1, go to FETCH.
- MEM:
  - Load: memRd=1, memToReg=1. On memReady go to WRITEBACK.
  - Store: memWr=1, held until memReady. Then PCWr=1 and go to FETCH.
- WRITEBACK: regWr=1, PCWr=1, go to FETCH.
  - memToReg=1 for loads.
  - regDataSel: 01 LUI, 10 AUIPC, 11 JAL/JALR, 00 otherwise.
  - branch=1 for JAL/JALR; ALUToPC=1 and ALUImm=1 for JALR.
- TRAP: illegal=1, all strobes 0. Stays in TRAP until reset.
- Latency at zero wait: ALU/U/J = 4 cycles, load = 5, store = 4, branch/FENCE = 3. Each memReady wait cycle adds 1.
- memReady outside FETCH/MEM is ignored.
- regWr, memWr and PCWr are never asserted in the same cycle as IRWr.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3), memReady=1 → states 0,1,2,4. IRWr in cycle 0; WRITEBACK cycle shows regWr=1, PCWr=1, ALUCtrl=0000.
- SUB (0x402081B3) → ALUCtrl=0001. SRAI x1,x1,3 (0x4030D093) → ALUCtrl=0111, ALUImm=1.
- LW x5,4(x1) (0x0040A283) with memReady low for 2 MEM cycles → states 0,1,2,3,3,3,4. memRd high in MEM; WRITEBACK shows memToReg=1, regWr=1, loadSel=10. Store SW x5,8(x1) (0x0050A423) → memWr=1 in MEM for one cycle, PCWr=1, regWr never asserted.
- BEQ x1,x2,+8 (0x00208463): ALUZero=1 → EXECUTE shows branch=1, PCWr=1, ALUCtrl=0001. ALUZero=0 → branch=0. Both cases take 3 cycles.
- Instruction 0x00000000 with TRAP_EN=1 → DECODE→TRAP, illegal=1 sticky, no PCWr. Reset clears illegal. With TRAP_EN=0 → retires in 3 cycles with only PCWr.
- Reset asserted during MEM of a store with memReady=0 → next cycle state=FETCH, memWr=0, no PCWr.
